// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction-fetch stage feeding the main decoder of the
//               single-cycle RISC-V core. Owns the program counter, requests
//               instruction words from instruction memory with a one-cycle
//               ready handshake, and holds the fetched word stable until the
//               decoder/writeback retires it. The next PC is PC+4 or the
//               branch/jump target. Misaligned taken targets and memory
//               timeouts raise sticky error flags and park the stage in ERR.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC       PC value loaded on reset
//   TIMEOUT        FETCH cycles without ready before timeout_err (1..255)
// Ports
//   clk            single clock, rising-edge active
//   reset          asynchronous, active-high reset
//   imem_req       fetch request to instruction memory (high in FETCH)
//   imem_addr      fetch address, always equal to pc
//   imem_rdata     instruction word, valid while imem_ready is high
//   imem_ready     memory accepts the request and returns data this cycle
//   instr          latched instruction word
//   op             instr[6:0], decoder opcode
//   instr_valid    instr/op/pc valid for the decoder (high in HOLD)
//   instr_ack      decoder/writeback retires the held instruction
//   stall          blocks retirement and PC update
//   pc_src         branch/jump taken
//   pc_target      branch/JAL target
//   pc             address of the held/fetching instruction
//   pc_plus4       pc + 4 (JAL link value)
//   misaligned_err sticky: a taken target had [1:0] != 0
//   timeout_err    sticky: memory did not respond within TIMEOUT cycles
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned_err,
    output logic        timeout_err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_fetch = 2'd0;
    localparam logic [1:0] c_st_hold  = 2'd1;
    localparam logic [1:0] c_st_err   = 2'd2;

    // The counter holds the number of ready-less FETCH cycles already
    // completed; the edge that would make it TIMEOUT raises the error instead.
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Registers and internal nets
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [7:0]  r_wait_cnt;
    logic        r_misaligned_err;
    logic        r_timeout_err;

    logic [31:0] w_pc_plus4;
    logic        w_retire;
    logic        w_target_misaligned;
    logic        w_wait_expired;

    // 32-bit add, wraps modulo 2^32 by construction.
    assign w_pc_plus4 = r_pc + 32'd4;

    // Retirement only counts in HOLD and only when not stalled; ack in any
    // other state is ignored.
    assign w_retire = (r_state == c_st_hold) && instr_ack && !stall;

    // Only a taken branch/jump can be misaligned; the sequential path is
    // always word-aligned because the PC itself never leaves alignment.
    assign w_target_misaligned = pc_src && (pc_target[1:0] != 2'b00);

    assign w_wait_expired = (r_state == c_st_fetch) && !imem_ready &&
                            (r_wait_cnt == c_wait_last);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_fetch: begin
                if (imem_ready) begin
                    w_next_state = c_st_hold;
                end else if (w_wait_expired) begin
                    w_next_state = c_st_err;
                end
            end
            c_st_hold: begin
                if (w_retire) begin
                    w_next_state = w_target_misaligned ? c_st_err : c_st_fetch;
                end
            end
            c_st_err: begin
                // Only reset leaves ERR.
                w_next_state = c_st_err;
            end
            default: begin
                // Unused encoding: restart fetching at the current PC.
                w_next_state = c_st_fetch;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (state-decoded only, no input-to-output path)
    // ------------------------------------------------------------------------
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            c_st_fetch: imem_req    = 1'b1;
            c_st_hold:  instr_valid = 1'b1;
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: PC, instruction latch, wait counter, sticky error flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_instr          <= 32'h0000_0000;
            r_wait_cnt       <= 8'd0;
            r_misaligned_err <= 1'b0;
            r_timeout_err    <= 1'b0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (imem_ready) begin
                        r_instr    <= imem_rdata;
                        r_wait_cnt <= 8'd0;
                    end else if (w_wait_expired) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                c_st_hold: begin
                    // pc_src/pc_target are looked at only on the retiring
                    // edge; a misaligned target leaves the PC pointing at the
                    // instruction that produced it.
                    if (w_retire) begin
                        if (w_target_misaligned) begin
                            r_misaligned_err <= 1'b1;
                        end else begin
                            r_pc <= pc_src ? pc_target : w_pc_plus4;
                        end
                    end
                end
                default: begin
                    // ERR (and the unused encoding): everything frozen.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign instr          = r_instr;
    assign op             = r_instr[6:0];
    assign misaligned_err = r_misaligned_err;
    assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch. A main instance
//               (RESET_PC=0, TIMEOUT=15) covers fetch, branch, stall, error
//               and async reset scenarios; a second instance with
//               RESET_PC=FFFF_FFFC covers PC wrap. Instruction memory returns
//               C0DE_0000 | address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        reset2;
    logic        imem_ready;
    logic        instr_ack;
    logic        stall;
    logic        pc_src;
    logic [31:0] pc_target;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic [31:0] instr, instr2;
    logic [6:0]  op, op2;
    logic        instr_valid, instr_valid2;
    logic [31:0] pc, pc2;
    logic [31:0] pc_plus4, pc_plus4_2;
    logic        misaligned_err, misaligned_err2;
    logic        timeout_err, timeout_err2;

    int checks;
    int errors;

    assign imem_rdata  = 32'hC0DE_0000 | imem_addr;
    assign imem_rdata2 = 32'hC0DE_0000 | imem_addr2;

    instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .instr(instr), .op(op),
        .instr_valid(instr_valid), .instr_ack(instr_ack), .stall(stall),
        .pc_src(pc_src), .pc_target(pc_target), .pc(pc), .pc_plus4(pc_plus4),
        .misaligned_err(misaligned_err), .timeout_err(timeout_err)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(15)) dut_wrap (
        .clk(clk), .reset(reset2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .imem_ready(imem_ready), .instr(instr2), .op(op2),
        .instr_valid(instr_valid2), .instr_ack(instr_ack), .stall(stall),
        .pc_src(pc_src), .pc_target(pc_target), .pc(pc2), .pc_plus4(pc_plus4_2),
        .misaligned_err(misaligned_err2), .timeout_err(timeout_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        @(negedge clk);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", instr, 32'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", imem_req); end
        checks++; if ({misaligned_err, timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {misaligned_err, timeout_err}); end
        reset = 1'b0;
    endtask

    task automatic test_seq_fetch();
        logic [31:0] exp_addr;
        @(negedge clk);
        imem_ready = 1'b1; instr_ack = 1'b1; stall = 1'b0; pc_src = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_addr = 32'(4 * k);
            checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", k, imem_addr, exp_addr); end
            checks++; if ({imem_req, instr_valid} !== 2'b10) begin errors++; $display("FAIL seq_fetch_ctl[%0d] got %b exp 10", k, {imem_req, instr_valid}); end
            @(negedge clk);
            checks++; if ({imem_req, instr_valid} !== 2'b01) begin errors++; $display("FAIL seq_hold_ctl[%0d] got %b exp 01", k, {imem_req, instr_valid}); end
            checks++; if (instr !== (32'hC0DE_0000 | exp_addr)) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", k, instr, 32'hC0DE_0000 | exp_addr); end
            checks++; if (op !== exp_addr[6:0]) begin errors++; $display("FAIL seq_op[%0d] got %h exp %h", k, op, exp_addr[6:0]); end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        // Entry: FETCH at pc=0x10 with ready/ack high.
        pc_src = 1'b1; pc_target = 32'h40;
        @(negedge clk);
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_pc got %h exp %h", pc, 32'h10); end
        checks++; if (pc_plus4 !== 32'h14) begin errors++; $display("FAIL br_pc_plus4 got %h exp %h", pc_plus4, 32'h14); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL br_valid got %b exp 1", instr_valid); end
        @(negedge clk);
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL br_target_addr got %h exp %h", imem_addr, 32'h40); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL br_req got %b exp 1", imem_req); end
        pc_src = 1'b0;
        imem_ready = 1'b0;
    endtask

    task automatic test_stall_wait();
        // Entry: FETCH at pc=0x40, ready low, ack held high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({imem_req, instr_valid} !== 2'b10) begin errors++; $display("FAIL wait_ctl[%0d] got %b exp 10", i, {imem_req, instr_valid}); end
            checks++; if (pc !== 32'h40) begin errors++; $display("FAIL wait_pc[%0d] got %h exp %h", i, pc, 32'h40); end
        end
        imem_ready = 1'b1; stall = 1'b1;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_rise got %b exp 1", instr_valid); end
        checks++; if (instr !== 32'hC0DE_0040) begin errors++; $display("FAIL stall_instr got %h exp %h", instr, 32'hC0DE_0040); end
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid[%0d] got %b exp 1", i, instr_valid); end
            checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_pc[%0d] got %h exp %h", i, pc, 32'h40); end
            checks++; if (instr !== 32'hC0DE_0040) begin errors++; $display("FAIL stall_instr_stable[%0d] got %h exp %h", i, instr, 32'hC0DE_0040); end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL stall_release_pc got %h exp %h", pc, 32'h44); end
        checks++; if ({imem_req, instr_valid} !== 2'b10) begin errors++; $display("FAIL stall_release_ctl got %b exp 10", {imem_req, instr_valid}); end
    endtask

    task automatic test_misaligned();
        // Entry: FETCH at pc=0x44.
        instr_ack = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mis_hold_valid got %b exp 1", instr_valid); end
        instr_ack = 1'b1; pc_src = 1'b1; pc_target = 32'h22; imem_ready = 1'b0;
        @(negedge clk);
        checks++; if (misaligned_err !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", misaligned_err); end
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL mis_pc got %h exp %h", pc, 32'h44); end
        checks++; if ({imem_req, instr_valid} !== 2'b00) begin errors++; $display("FAIL mis_ctl got %b exp 00", {imem_req, instr_valid}); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL mis_timeout got %b exp 0", timeout_err); end
        pc_src = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({misaligned_err, imem_req, instr_valid} !== 3'b100) begin errors++; $display("FAIL mis_sticky[%0d] got %b exp 100", i, {misaligned_err, imem_req, instr_valid}); end
            checks++; if ({pc, instr} !== {32'h44, 32'hC0DE_0044}) begin errors++; $display("FAIL mis_frozen[%0d] got %h/%h exp 44/c0de0044", i, pc, instr); end
        end
        instr_ack = 1'b0;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        reset = 1'b1; imem_ready = 1'b0; instr_ack = 1'b1; stall = 1'b0; pc_src = 1'b0;
        #1;
        checks++; if (misaligned_err !== 1'b0) begin errors++; $display("FAIL to_reset_mis got %b exp 0", misaligned_err); end
        @(negedge clk);
        reset = 1'b0;
        // 10 waits, then a hit: the counter must clear so it cannot accumulate.
        repeat (10) @(negedge clk);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL to_pc got %h exp %h", pc, 32'h4); end
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            checks++; if ({timeout_err, imem_req} !== 2'b01) begin errors++; $display("FAIL to_early[%0d] got %b exp 01", i, {timeout_err, imem_req}); end
        end
        @(negedge clk);
        checks++; if ({timeout_err, imem_req, instr_valid} !== 3'b100) begin errors++; $display("FAIL to_fire got %b exp 100", {timeout_err, imem_req, instr_valid}); end
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({timeout_err, pc} !== {1'b1, 32'h4}) begin errors++; $display("FAIL to_sticky got %b/%h exp 1/4", timeout_err, pc); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reset = 1'b1; imem_ready = 1'b0; instr_ack = 1'b0; pc_src = 1'b0;
        @(negedge clk);
        reset = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        instr_ack = 1'b1; pc_src = 1'b1; pc_target = 32'h80;
        @(negedge clk);
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL ar_jump_pc got %h exp %h", pc, 32'h80); end
        instr_ack = 1'b0; pc_src = 1'b0;
        @(negedge clk);
        checks++; if ({instr_valid, instr} !== {1'b1, 32'hC0DE_0080}) begin errors++; $display("FAIL ar_hold got %b/%h exp 1/c0de0080", instr_valid, instr); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({pc, instr} !== {32'h0, 32'h0}) begin errors++; $display("FAIL ar_immediate got %h/%h exp 0/0", pc, instr); end
        checks++; if ({imem_req, instr_valid} !== 2'b10) begin errors++; $display("FAIL ar_immediate_ctl got %b exp 10", {imem_req, instr_valid}); end
        @(negedge clk);
        checks++; if ({instr_valid, instr} !== {1'b0, 32'h0}) begin errors++; $display("FAIL ar_ready_discard got %b/%h exp 0/0", instr_valid, instr); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h0, 32'hC0DE_0000}) begin errors++; $display("FAIL ar_restart got %b/%h/%h exp 1/0/c0de0000", instr_valid, pc, instr); end
    endtask

    task automatic test_wrap();
        reset2 = 1'b0; imem_ready = 1'b1; instr_ack = 1'b1; stall = 1'b0; pc_src = 1'b0;
        checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_addr got %h exp fffffffc", imem_addr2); end
        checks++; if (pc_plus4_2 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got %h exp 0", pc_plus4_2); end
        @(negedge clk);
        checks++; if ({instr_valid2, instr2, op2} !== {1'b1, 32'hFFFF_FFFC, 7'h7C}) begin errors++; $display("FAIL wrap_hold got %b/%h/%h exp 1/fffffffc/7c", instr_valid2, instr2, op2); end
        @(negedge clk);
        checks++; if ({imem_addr2, pc2} !== {32'h0, 32'h0}) begin errors++; $display("FAIL wrap_next got %h/%h exp 0/0", imem_addr2, pc2); end
        checks++; if ({imem_req2, misaligned_err2, timeout_err2} !== 3'b100) begin errors++; $display("FAIL wrap_ctl got %b exp 100", {imem_req2, misaligned_err2, timeout_err2}); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; reset2 = 1'b1;
        imem_ready = 1'b0; instr_ack = 1'b0; stall = 1'b0;
        pc_src = 1'b0; pc_target = 32'h0;
        test_reset();
        test_seq_fetch();
        test_branch();
        test_stall_wait();
        test_misaligned();
        test_timeout();
        test_async_reset();
        @(negedge clk);
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
